// File: rtl/hash_rd_agu_if.sv
// Read request channel from the hash read AGU to the sample RAM / consumer.
// master drives address and lane; slave returns ready.
interface hash_rd_agu_if;
    logic        rd_valid;
    logic        rd_ready;
    logic [11:0] rd_addr;
    logic [2:0]  rd_bias;

    modport master (
        output rd_valid,
        output rd_addr,
        output rd_bias,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_addr,
        input  rd_bias,
        output rd_ready
    );
endinterface

// File: rtl/hash_rd_agu.sv
// Read-side address generator for the FrodoKEM hash output buffers.
// Optional beat counter output: define HASH_RD_AGU_BEATCNT_EN.
module hash_rd_agu #(
    parameter int RD_LAT = 1,
    parameter int NBAR   = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    input  logic [2:0]  mode,
    input  logic [1:0]  level,
    input  logic [11:0] len_b,
    hash_rd_agu_if.master rd,
    output logic        tag_valid,
    output logic [2:0]  tag_bias,
    output logic        busy,
    output logic        done,
`ifdef HASH_RD_AGU_BEATCNT_EN
    output logic [15:0] beat_cnt,
`endif
    output logic        start_err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [2:0] BMAX = 3'(NBAR - 1);
    localparam logic [RD_LAT-1:0] TAG_TOP = RD_LAT'(1 << (RD_LAT - 1));

    state_t                  state_q, state_d;
    logic [2:0]              mode_q, mode_d;
    logic [11:0]             last_q, last_d;
    logic [11:0]             cnt_q, cnt_d;
    logic [2:0]              bias_q, bias_d;
    logic                    err_q, err_d;
    logic [RD_LAT-1:0]       tag_v_q, tag_v_d;
    logic [RD_LAT-1:0][2:0]  tag_b_q, tag_b_d;

    logic        fire;
    logic        mode_ok;
    logic        is_last;
    logic [11:0] lvl_last;

    assign rd.rd_valid = (state_q == RUN);
    assign rd.rd_bias  = bias_q;
    assign rd.rd_addr  = (mode_q == 3'b101) ? {cnt_q[10:0], 1'b0} : cnt_q;
    assign fire        = rd.rd_valid & rd.rd_ready;

    assign busy      = (state_q != IDLE);
    assign start_err = err_q;
    assign tag_valid = tag_v_q[RD_LAT-1];
    assign tag_bias  = tag_b_q[RD_LAT-1];
    assign done      = (state_q == DRAIN) && (tag_v_q == TAG_TOP) && !abort;

    // decode mode validity, level bound and final-beat condition
    always_comb begin
        mode_ok  = (mode == 3'b000) || (mode == 3'b001) ||
                   (mode == 3'b100) || (mode == 3'b101);
        lvl_last = 12'd0;
        case (level)
            2'b01:   lvl_last = 12'd1343;
            2'b10:   lvl_last = 12'd975;
            2'b11:   lvl_last = 12'd639;
            default: lvl_last = 12'd0;
        endcase
        is_last = 1'b1;
        case (mode_q)
            3'b000,
            3'b001:  is_last = (cnt_q == last_q) && (bias_q == BMAX);
            3'b100:  is_last = (cnt_q == last_q);
            3'b101:  is_last = (cnt_q == last_q) && (bias_q == 3'd7);
            default: is_last = 1'b1;
        endcase
    end

    // next-state, walk counters and tag shift register
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        bias_d  = bias_q;
        err_d   = 1'b0;
        tag_v_d = '0;
        tag_b_d = '0;
        tag_v_d[0] = fire;
        tag_b_d[0] = fire ? bias_q : 3'd0;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_b_d[i] = tag_b_q[i-1];
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (mode_ok) begin
                        state_d = RUN;
                        mode_d  = mode;
                        last_d  = (mode == 3'b100) ? len_b : lvl_last;
                        cnt_d   = 12'd0;
                        bias_d  = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (fire) begin
                    if (is_last) begin
                        state_d = DRAIN;
                    end else begin
                        case (mode_q)
                            3'b000: begin
                                if (cnt_q == last_q) begin
                                    cnt_d  = 12'd0;
                                    bias_d = bias_q + 3'd1;
                                end else begin
                                    cnt_d = cnt_q + 12'd1;
                                end
                            end
                            3'b001: begin
                                if (bias_q == BMAX) begin
                                    bias_d = 3'd0;
                                    cnt_d  = cnt_q + 12'd1;
                                end else begin
                                    bias_d = bias_q + 3'd1;
                                end
                            end
                            3'b100: cnt_d = cnt_q + 12'd1;
                            3'b101: begin
                                if (!bias_q[0]) begin
                                    bias_d = bias_q | 3'd1;
                                end else if (cnt_q == last_q) begin
                                    cnt_d  = 12'd0;
                                    bias_d = bias_q + 3'd1;
                                end else begin
                                    cnt_d  = cnt_q + 12'd1;
                                    bias_d = bias_q & 3'b110;
                                end
                            end
                            default: state_d = DRAIN;
                        endcase
                    end
                end
            end
            DRAIN: begin
                if (tag_v_q == TAG_TOP) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            mode_d  = 3'd0;
            last_d  = 12'd0;
            cnt_d   = 12'd0;
            bias_d  = 3'd0;
            err_d   = 1'b0;
            tag_v_d = '0;
            tag_b_d = '0;
        end
    end

    // state and counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            mode_q  <= 3'd0;
            last_q  <= 12'd0;
            cnt_q   <= 12'd0;
            bias_q  <= 3'd0;
            err_q   <= 1'b0;
            tag_v_q <= '0;
            tag_b_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            bias_q  <= bias_d;
            err_q   <= err_d;
            tag_v_q <= tag_v_d;
            tag_b_q <= tag_b_d;
        end
    end

`ifdef HASH_RD_AGU_BEATCNT_EN
    logic [15:0] beat_q, beat_d;

    // saturating count of fires since the last accepted start
    always_comb begin
        beat_d = beat_q;
        if (fire && (beat_q != 16'hFFFF)) beat_d = beat_q + 16'd1;
        if ((state_q == IDLE) && start && mode_ok) beat_d = 16'd0;
        if (abort) beat_d = 16'd0;
    end

    // beat counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) beat_q <= 16'd0;
        else       beat_q <= beat_d;
    end

    assign beat_cnt = beat_q;
`endif

endmodule

// File: tb/tb_hash_rd_agu.sv
// Testbench for hash_rd_agu: vector table of walks plus hand sequences
// for stall, abort, invalid start and start-while-busy.
module tb_hash_rd_agu;

    localparam int RD_LAT = 1;

    typedef struct {
        logic [11:0] addr;
        logic [2:0]  bias;
    } beat_t;

    typedef struct {
        logic [2:0] bias;
        int         cyc;
    } tag_t;

    typedef struct {
        logic [2:0]  mode;
        logic [1:0]  level;
        logic [11:0] len_b;
        int          rdy;
        int          beats;
        logic [11:0] last_addr;
        logic [2:0]  last_bias;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [1:0]  level = 2'd0;
    logic [11:0] len_b = 12'd0;
    logic        tag_valid;
    logic [2:0]  tag_bias;
    logic        busy;
    logic        done;
    logic        start_err;
`ifdef HASH_RD_AGU_BEATCNT_EN
    logic [15:0] beat_cnt;
`endif

    int   rdy_mode = 0;
    logic man_rdy = 1'b1;
    logic rnd_rdy = 1'b1;

    int nchk = 0;
    int npass = 0;
    int cyc = 0;
    int fires = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_fire_cyc = 0;
    int walk_d0 = 0;
    logic [11:0] last_a = 12'd0;
    logic [2:0]  last_b = 3'd0;
    logic        prev_stall = 1'b0;
    logic [11:0] prev_a = 12'd0;
    logic [2:0]  prev_b = 3'd0;

    beat_t exp_q[$];
    tag_t  tag_q[$];
    beat_t blog[4096];
    vec_t  tv[10];

    hash_rd_agu_if rd();

    assign rd.rd_ready = (rdy_mode == 2) ? man_rdy :
                         (rdy_mode == 1) ? rnd_rdy : 1'b1;

    hash_rd_agu #(.RD_LAT(RD_LAT), .NBAR(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .level     (level),
        .len_b     (len_b),
        .rd        (rd.master),
        .tag_valid (tag_valid),
        .tag_bias  (tag_bias),
        .busy      (busy),
        .done      (done),
`ifdef HASH_RD_AGU_BEATCNT_EN
        .beat_cnt  (beat_cnt),
`endif
        .start_err (start_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        rnd_rdy = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string nm, input longint act, input longint expv);
        nchk++;
        if (act == expv) npass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    endtask

    task automatic gen_exp(input logic [2:0] m, input logic [1:0] l,
                           input logic [11:0] lb);
        int last;
        case (l)
            2'b01:   last = 1343;
            2'b10:   last = 975;
            2'b11:   last = 639;
            default: last = 0;
        endcase
        case (m)
            3'b000:
                for (int b = 0; b < 8; b++)
                    for (int a = 0; a <= last; a++)
                        exp_q.push_back('{12'(a), 3'(b)});
            3'b001:
                for (int a = 0; a <= last; a++)
                    for (int b = 0; b < 8; b++)
                        exp_q.push_back('{12'(a), 3'(b)});
            3'b100:
                for (int a = 0; a <= int'(lb); a++)
                    exp_q.push_back('{12'(a), 3'd0});
            3'b101:
                for (int g = 0; g < 4; g++)
                    for (int h = 0; h <= last; h++)
                        for (int k = 0; k < 2; k++)
                            exp_q.push_back('{12'(2 * h), 3'(2 * g + k)});
            default: ;
        endcase
    endtask

    // monitor: scoreboard pops on fire, tag and done tracking
    always @(negedge clk) begin : mon
        beat_t e;
        tag_t  t;
        if (rstn) begin
            if (prev_stall)
                chk("hold", {rd.rd_valid, rd.rd_addr, rd.rd_bias},
                    {1'b1, prev_a, prev_b});
            if (rd.rd_valid && rd.rd_ready) begin
                if (fires < 4096) blog[fires] = '{rd.rd_addr, rd.rd_bias};
                fires++;
                if (exp_q.size() == 0) begin
                    chk("extra_fire", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("beat%0d", fires), {rd.rd_addr, rd.rd_bias},
                        {e.addr, e.bias});
                end
                tag_q.push_back('{rd.rd_bias, cyc});
                last_fire_cyc = cyc;
                last_a = rd.rd_addr;
                last_b = rd.rd_bias;
            end
            if (tag_valid) begin
                if (tag_q.size() == 0) begin
                    chk("extra_tag", 1, 0);
                end else begin
                    t = tag_q.pop_front();
                    chk("tag_bias", tag_bias, t.bias);
                    chk("tag_lat", cyc - t.cyc, RD_LAT);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_with_tag", tag_valid, 1);
            end
            prev_stall = rd.rd_valid && !rd.rd_ready;
            prev_a = rd.rd_addr;
            prev_b = rd.rd_bias;
        end
    end

    task automatic begin_walk(input vec_t v);
        rdy_mode = v.rdy;
        man_rdy = 1'b1;
        fires = 0;
        walk_d0 = done_cnt;
        exp_q.delete();
        gen_exp(v.mode, v.level, v.len_b);
        start = 1'b1;
        mode = v.mode;
        level = v.level;
        len_b = v.len_b;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("first_valid", rd.rd_valid, 1);
        chk("busy_run", busy, 1);
        chk("no_err", start_err, 0);
        mode = 3'b010;
        level = ~v.level;
        len_b = v.len_b + 12'd7;
    endtask

    task automatic finish_walk(input vec_t v);
        int n = 0;
        int budget = v.beats * 4 + 50;
        while (done_cnt == walk_d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_cnt", done_cnt - walk_d0, 1);
        chk("fires", fires, v.beats);
        chk("exp_left", exp_q.size(), 0);
        chk("tag_left", tag_q.size(), 0);
        chk("last_beat", {last_a, last_b}, {v.last_addr, v.last_bias});
        chk("done_lat", done_cyc - last_fire_cyc, RD_LAT);
        chk("busy_end", busy, 0);
`ifdef HASH_RD_AGU_BEATCNT_EN
        chk("beat_cnt", beat_cnt, v.beats);
`endif
    endtask

    initial begin : main
        vec_t v;
        logic [2:0] bad [4];
        int n;
        tv[0] = '{3'b000, 2'b11, 12'd0,   0, 5120,  12'd639,  3'd7};
        tv[1] = '{3'b001, 2'b11, 12'd0,   0, 5120,  12'd639,  3'd7};
        tv[2] = '{3'b101, 2'b01, 12'd0,   0, 10752, 12'd2686, 3'd7};
        tv[3] = '{3'b100, 2'b00, 12'd5,   1, 6,     12'd5,    3'd0};
        tv[4] = '{3'b000, 2'b00, 12'd0,   1, 8,     12'd0,    3'd7};
        tv[5] = '{3'b001, 2'b00, 12'd0,   1, 8,     12'd0,    3'd7};
        tv[6] = '{3'b101, 2'b00, 12'd0,   1, 8,     12'd0,    3'd7};
        tv[7] = '{3'b100, 2'b10, 12'd100, 1, 101,   12'd100,  3'd0};
        tv[8] = '{3'b001, 2'b10, 12'd0,   0, 7808,  12'd975,  3'd7};
        tv[9] = '{3'b101, 2'b11, 12'd0,   1, 5120,  12'd1278, 3'd7};
        bad[0] = 3'b010;
        bad[1] = 3'b011;
        bad[2] = 3'b110;
        bad[3] = 3'b111;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", rd.rd_valid, 0);
        chk("rst_addr", {rd.rd_addr, rd.rd_bias}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tag", {tag_valid, tag_bias}, 0);
        chk("rst_err", start_err, 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            begin_walk(tv[i]);
            finish_walk(tv[i]);
            if (i == 0) begin
                chk("m0_b640", {blog[639].addr, blog[639].bias}, {12'd639, 3'd0});
                chk("m0_b641", {blog[640].addr, blog[640].bias}, {12'd0, 3'd1});
            end
            if (i == 1) begin
                chk("m1_b8", {blog[7].addr, blog[7].bias}, {12'd0, 3'd7});
                chk("m1_b9", {blog[8].addr, blog[8].bias}, {12'd1, 3'd0});
            end
            if (i == 2) begin
                chk("m5_b3", {blog[2].addr, blog[2].bias}, {12'd2, 3'd0});
                chk("m5_b2688", {blog[2687].addr, blog[2687].bias},
                    {12'd2686, 3'd1});
                chk("m5_b2689", {blog[2688].addr, blog[2688].bias},
                    {12'd0, 3'd2});
            end
        end

        // stall at addr 2 in mode 100
        v = '{3'b100, 2'b00, 12'd5, 2, 6, 12'd5, 3'd0};
        begin_walk(v);
        n = 0;
        while (!(rd.rd_valid && rd.rd_addr == 12'd2) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        man_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_addr", {rd.rd_valid, rd.rd_addr}, {1'b1, 12'd2});
            @(posedge clk);
            #1;
        end
        man_rdy = 1'b1;
        finish_walk(v);

        // abort after beat 100 of mode 000
        v = tv[0];
        begin_walk(v);
        n = 0;
        while (fires < 100 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_valid", rd.rd_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_tag", tag_valid, 0);
        chk("abort_done", done, 0);
        exp_q.delete();
        tag_q.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("abort_nodone", done_cnt - walk_d0, 0);
        chk("abort_idle", {busy, rd.rd_valid}, 0);
        v = '{3'b000, 2'b00, 12'd0, 0, 8, 12'd0, 3'd7};
        begin_walk(v);
        finish_walk(v);
        chk("restart_first", {blog[0].addr, blog[0].bias}, 0);

        // invalid modes raise start_err only
        rdy_mode = 0;
        for (int k = 0; k < 4; k++) begin
            start = 1'b1;
            mode = bad[k];
            @(posedge clk);
            #1;
            start = 1'b0;
            chk("err_pulse", start_err, 1);
            chk("err_busy", busy, 0);
            @(posedge clk);
            #1;
            chk("err_clear", {start_err, rd.rd_valid}, 0);
        end

        // start while busy is ignored
        v = '{3'b100, 2'b00, 12'd20, 0, 21, 12'd20, 3'd0};
        begin_walk(v);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        mode = 3'b000;
        level = 2'b11;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_start_err", start_err, 0);
        chk("busy_start_run", busy, 1);
        finish_walk(v);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/hash_rd_agu.md
Name: hash_rd_agu

Overview:
- Read-side address generator for the hash output buffers (S, S', E', E, B, B') that the hash write path fills in FrodoKEM.
- Walks the same memory layouts in the same orders the writer used. Emits a read address plus a 3-bit lane select (bias) toward the sample RAM, with a valid/ready handshake to the consumer (matrix-mult / pack unit).
- Tracks in-flight reads through a fixed-latency pipeline and raises done after the last datum returns.

Parameters:
- RD_LAT, 1, sample-RAM read latency in cycles (1..3); delay from fire to tag_valid.
- NBAR, 8, number of lanes per address in modes 000/001 (bias range 0..NBAR-1).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches mode/level/len_b, begins a walk; ignored unless IDLE
- abort  in  1  synchronous clear; returns to IDLE from any state
- mode  in  3  000 S/S'/E', 001 E, 100 B, 101 B'; other codes invalid
- level  in  2  01→last=1343, 10→last=975, 11→last=639, 00→last=0
- len_b  in  12  last address for mode 100
- rd_valid  out  1  rd_addr/rd_bias valid
- rd_ready  in  1  consumer/RAM accepts; fire = rd_valid & rd_ready
- rd_addr  out  12  read address
- rd_bias  out  3  lane select
- tag_valid  out  1  RD_LAT cycles after each fire
- tag_bias  out  3  rd_bias of that fire, delayed RD_LAT
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse at walk completion
- start_err  out  1  one-cycle pulse when start arrives with an invalid mode

Behaviour:
- Reset and abort values: all outputs 0, state IDLE, counters 0, tag pipeline emptied. abort overrides start in the same cycle.
- FSM:
  - IDLE: start with a valid mode → RUN. Next cycle rd_valid=1 with addr 0, bias 0.
  - RUN: advance on fire only. After firing the final beat, rd_valid drops the next cycle → DRAIN.
  - DRAIN: wait until the last tag_valid is emitted; assert done in that same cycle → IDLE.
- Invalid mode on start: stay IDLE, start_err=1 for one cycle, done never asserted.
- start while busy: ignored, no error.
- Handshake: rd_addr/rd_bias hold stable while rd_valid & !rd_ready. rd_valid never drops in RUN before the final fire. No combinational path from rd_ready to rd_valid.
- Address order per fire (last = level value, latched at start):
  - 000: addr++ with bias fixed. At addr==last: addr←0, bias++. Final beat is addr==last, bias==NBAR-1. Total (last+1)*NBAR beats.
  - 001: bias++ with addr fixed. At bias==NBAR-1: bias←0, addr++. Final beat is addr==last, bias==NBAR-1. Same beat count, transposed order.
  - 100: addr++ with bias 0. Final beat is addr==len_b. Total len_b+1 beats.
  - 101: rd_addr={half,1'b0}, rd_bias={grp,lane}. lane toggles every fire. When lane==1: if half==last then half←0, grp++; else half++. Final beat is grp==3, half==last, lane==1. Total 8*(last+1) beats.
- Counters are 12 bits with no overflow beyond the final beat. Level 00 gives an 8-beat walk in modes 000/001/101.
- Tag pipeline: a shift register of RD_LAT stages carrying {valid,bias}. It shifts every cycle regardless of rd_ready.
- Latency: start→first rd_valid is 1 cycle; final fire→done is RD_LAT cycles.
- level/mode/len_b changes during RUN have no effect (latched copies).

Optional Feature:
- Macro: HASH_RD_AGU_BEATCNT_EN.
- Defined: adds output beat_cnt[15:0], the count of fires since the last start. Cleared on start/abort/reset; holds its final value after done. Saturates at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- level=11, mode=000, rd_ready=1 → 5120 fires; beat 640 is addr 639 bias 0, beat 641 is addr 0 bias 1; last is addr 639 bias 7; done 1 cycle after last fire (RD_LAT=1).
- level=11, mode=001 → order (0,0),(0,1)…(0,7),(1,0); last (639,7); 5120 fires.
- level=01, mode=101 → (0,0),(0,1),(2,0),(2,1)…(2686,1),(0,2); last (2686,7); 10752 fires.
- mode=100, len_b=5, rd_ready low 3 cycles at addr 2 → addr 2 held 3 cycles; addresses 0..5 each fire once; tag_bias all 0.
- abort asserted at beat 100 of mode 000 → next cycle rd_valid=0, busy=0, tag_valid=0, no done; new start restarts at addr 0 bias 0.
- start with mode=010 → start_err pulse, busy stays 0; start with mode=000 while busy → ignored, sequence uninterrupted.
